tdc_ctrl: RTL and testbench

- Digital sequencer and sampler for the TDC analog front end.
- Powers the front end up in order (pd, then pd_inj) and waits a programmable settle time after each release.
- Then samples the 7-bit ripple counter and the 16-tap phase thermometer every clk cycle.
- Produces a per-cycle phase-increment word for the ADPLL loop filter, plus ready/error status.

---
 rtl/tdc_pkg.sv | 21 ++
 rtl/tdc_therm_decode.sv | 29 ++
 rtl/tdc_ctrl.sv | 114 +++++++++++
 tb/tb_tdc_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and widths for the TDC front-end sequencer/sampler.
// Widths match the analog front end: 7-bit ripple counter, 16 phase taps.
`timescale 1ns/1ps
package tdc_pkg;

  localparam int CNT_W    = 7;
  localparam int PH_N     = 16;
  localparam int FINE_W   = 4;
  localparam int SETTLE_W = 8;

  typedef enum logic [2:0] {
    OFF,
    PD_WAIT,
    INJ_WAIT,
    PRIME,
    TRACK
  } tdc_state_t;

  typedef logic [CNT_W+FINE_W-1:0] tdc_pos_t;

endpackage

// File: rtl/tdc_therm_decode.sv
// Phase thermometer decode: fine = popcount saturated to PH_N-1, clean = ones contiguous from bit 0.
// Purely combinational, no backpressure.
`timescale 1ns/1ps
module tdc_therm_decode
  import tdc_pkg::*;
(
  input  logic [PH_N-1:0]   phase,
  output logic [FINE_W-1:0] fine,
  output logic              clean
);

  logic [FINE_W:0]   ones;
  logic [PH_N-1:0]   phase_inc;

  always_comb begin
    ones = '0;
    for (int i = 0; i < PH_N; i++) begin
      ones = ones + (FINE_W+1)'(phase[i]);
    end
  end

  // All taps set is the only way to reach PH_N, so the top bit alone flags saturation.
  assign fine      = ones[FINE_W] ? {FINE_W{1'b1}} : ones[FINE_W-1:0];

  // A clean code is 2^k-1, so adding one clears every set bit.
  assign phase_inc = phase + PH_N'(1);
  assign clean     = ((phase & phase_inc) == '0);

endmodule

// File: rtl/tdc_ctrl.sv
// TDC front-end power sequencer and phase sampler producing per-clk phase increments.
// Inputs registered once, tdc_word one cycle later; no backpressure (one word per clk in TRACK).
`timescale 1ns/1ps
module tdc_ctrl
  import tdc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SETTLE_W-1:0] pd_settle,
  input  logic [SETTLE_W-1:0] inj_settle,
  input  logic [CNT_W-1:0]    ripple_count,
  input  logic [PH_N-1:0]     phase,
  output logic                pd,
  output logic                pd_inj,
  output tdc_pos_t            tdc_word,
  output logic                tdc_valid,
  output logic                ready,
  output logic                bubble_err
);

  tdc_state_t          state, next_state;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [CNT_W-1:0]    ripple_q;
  logic [PH_N-1:0]     phase_q;
  tdc_pos_t            prev_pos;
  tdc_pos_t            pos_c;
  logic [FINE_W-1:0]   fine;
  logic                clean;
  logic                track_step;

  tdc_therm_decode u_decode (
    .phase (phase_q),
    .fine  (fine),
    .clean (clean)
  );

  assign pos_c      = {ripple_q, fine};
  assign track_step = (state == TRACK) && en;

  always_comb begin
    next_state = state;
    settle_nxt = settle_cnt;
    case (state)
      OFF: begin
        if (en) begin
          next_state = PD_WAIT;
          settle_nxt = pd_settle;
        end
      end
      PD_WAIT: begin
        if (settle_cnt == '0) begin
          next_state = INJ_WAIT;
          settle_nxt = inj_settle;
        end else begin
          settle_nxt = settle_cnt - SETTLE_W'(1);
        end
      end
      INJ_WAIT: begin
        if (settle_cnt == '0) begin
          next_state = PRIME;
        end else begin
          settle_nxt = settle_cnt - SETTLE_W'(1);
        end
      end
      PRIME:   next_state = TRACK;
      TRACK:   next_state = TRACK;
      default: next_state = OFF;
    endcase
    if (!en) begin
      next_state = OFF;
      settle_nxt = '0;
    end
  end

  // Power-down and status outputs are registered from next_state so the analog pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      settle_cnt <= '0;
      ripple_q   <= '0;
      phase_q    <= '0;
      prev_pos   <= '0;
      tdc_word   <= '0;
      tdc_valid  <= 1'b0;
      pd         <= 1'b1;
      pd_inj     <= 1'b1;
      ready      <= 1'b0;
      bubble_err <= 1'b0;
    end else begin
      state      <= next_state;
      settle_cnt <= settle_nxt;
      ripple_q   <= ripple_count;
      phase_q    <= phase;
      pd         <= (next_state == OFF);
      pd_inj     <= (next_state inside {OFF, PD_WAIT});
      ready      <= (next_state == TRACK);
      tdc_valid  <= track_step;
      if (track_step) begin
        tdc_word <= pos_c - prev_pos;
      end
      // prev_pos survives power-down; PRIME re-seeds it on every new entry.
      if ((state == PRIME) || track_step) begin
        prev_pos <= pos_c;
      end
      if (next_state == OFF) begin
        bubble_err <= 1'b0;
      end else if (track_step && !clean) begin
        bubble_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdc_ctrl.sv
// Bench for tdc_ctrl: power-up timing, steady tracking, wrap, decode table, bubble, abort, async reset.
`timescale 1ns/1ps
module tb_tdc_ctrl;
  import tdc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  pd_settle = 8'd0;
  logic [7:0]  inj_settle = 8'd0;
  logic [6:0]  ripple_count = 7'd0;
  logic [15:0] phase = 16'd0;
  logic        pd, pd_inj, tdc_valid, ready, bubble_err;
  logic [10:0] tdc_word;

  tdc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pd_settle    (pd_settle),
    .inj_settle   (inj_settle),
    .ripple_count (ripple_count),
    .phase        (phase),
    .pd           (pd),
    .pd_inj       (pd_inj),
    .tdc_word     (tdc_word),
    .tdc_valid    (tdc_valid),
    .ready        (ready),
    .bubble_err   (bubble_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ripple;
    logic [15:0] phase;
    logic [3:0]  fine;
    logic        clean;
  } vec_t;

  vec_t        vecs [9];
  logic [10:0] sb [$];
  logic [10:0] prev_pos = 11'd0;
  logic [10:0] exp_w;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every valid word must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && tdc_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tdc_word: got unexpected valid word %0d, expected none", tdc_word);
      end else begin
        exp_w = sb.pop_front();
        check("tdc_word", tdc_word, exp_w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] therm(input int f);
    logic [16:0] one;
    one = 17'd1;
    return 16'((one << f) - 17'd1);
  endfunction

  // exp < 0: expected word derived from the bench position model; otherwise taken literally.
  task automatic drive(input logic [6:0] r, input logic [15:0] ph, input logic [3:0] f, input int exp);
    logic [10:0] pos;
    ripple_count = r;
    phase        = ph;
    pos          = {r, f};
    if (exp < 0) sb.push_back(pos - prev_pos);
    else         sb.push_back(11'(exp));
    prev_pos = pos;
    tick();
  endtask

  task automatic power_up(input logic [7:0] ps, input logic [7:0] is,
                          output int c_pd, output int c_inj, output int c_rdy, output int c_vld);
    c_pd = -1; c_inj = -1; c_rdy = -1; c_vld = -1;
    ripple_count = 7'd0;
    phase        = 16'd0;
    prev_pos     = 11'd0;
    pd_settle    = ps;
    inj_settle   = is;
    en           = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c_pd  < 0 && !pd)     c_pd  = c;
      if (c_inj < 0 && !pd_inj) c_inj = c;
      if (c_rdy < 0 && ready)   c_rdy = c;
      if (ready) sb.push_back(11'd0);
      if (tdc_valid) begin
        c_vld = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c_pd, c_inj, c_rdy, c_vld;
    logic sticky;

    vecs[0] = '{ripple: 7'd10, phase: 16'h0000, fine: 4'd0,  clean: 1'b1};
    vecs[1] = '{ripple: 7'd11, phase: 16'h0001, fine: 4'd1,  clean: 1'b1};
    vecs[2] = '{ripple: 7'd12, phase: 16'h00FF, fine: 4'd8,  clean: 1'b1};
    vecs[3] = '{ripple: 7'd13, phase: 16'h7FFF, fine: 4'd15, clean: 1'b1};
    vecs[4] = '{ripple: 7'd14, phase: 16'hFFFF, fine: 4'd15, clean: 1'b1};
    vecs[5] = '{ripple: 7'd15, phase: 16'h0FFF, fine: 4'd12, clean: 1'b1};
    vecs[6] = '{ripple: 7'd16, phase: 16'h0002, fine: 4'd1,  clean: 1'b0};
    vecs[7] = '{ripple: 7'd17, phase: 16'h8000, fine: 4'd1,  clean: 1'b0};
    vecs[8] = '{ripple: 7'd18, phase: 16'h0003, fine: 4'd2,  clean: 1'b1};

    // Reset values
    #12;
    check("rst_pd", pd, 1);
    check("rst_pd_inj", pd_inj, 1);
    check("rst_tdc_word", tdc_word, 0);
    check("rst_tdc_valid", tdc_valid, 0);
    check("rst_ready", ready, 0);
    check("rst_bubble_err", bubble_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Power-up with settle 5/3
    power_up(8'd5, 8'd3, c_pd, c_inj, c_rdy, c_vld);
    check("pu_pd_fall", c_pd, 1);
    check("pu_inj_fall", c_inj, 7);
    check("pu_ready_rise", c_rdy, 12);
    check("pu_valid_rise", c_vld, 13);

    // 2.5 GHz vs 32 MHz: 1250 sixteenth-cycles per clk
    for (int k = 1; k <= 40; k++) begin
      int p;
      p = k * 1250;
      drive(7'((p >> 4) & 127), therm(p & 15), 4'(p & 15), 1250);
    end
    check("steady_bubble", bubble_err, 0);

    // Ripple wrap 120 -> 5: (82 - 1935) mod 2048
    drive(7'd120, 16'h7FFF, 4'd15, -1);
    drive(7'd5,   16'h0003, 4'd2,  195);

    // Decode table; bubble flag is sticky from the first dirty sample on
    sticky = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ripple, vecs[i].phase, vecs[i].fine, -1);
      if (i > 0) begin
        sticky = sticky | !vecs[i-1].clean;
        check("tbl_bubble_err", bubble_err, sticky);
      end
    end
    drive(vecs[8].ripple, vecs[8].phase, vecs[8].fine, 0);
    check("tbl_bubble_err_last", bubble_err, 1);

    // Power-down from TRACK clears status and the sticky flag
    en = 1'b0;
    void'(sb.pop_back());
    tick();
    check("off_pd", pd, 1);
    check("off_pd_inj", pd_inj, 1);
    check("off_ready", ready, 0);
    check("off_valid", tdc_valid, 0);
    check("off_bubble_err", bubble_err, 0);

    // Abort in INJ_WAIT with counter at 2, then immediate re-enable
    ripple_count = 7'd0;
    phase        = 16'd0;
    pd_settle    = 8'd5;
    inj_settle   = 8'd3;
    en           = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("abort_in_inj_wait", dut.state, INJ_WAIT);
    en = 1'b0;
    tick();
    check("abort_pd", pd, 1);
    check("abort_pd_inj", pd_inj, 1);
    check("abort_ready", ready, 0);
    power_up(8'd5, 8'd3, c_pd, c_inj, c_rdy, c_vld);
    check("reen_pd_fall", c_pd, 1);
    check("reen_inj_fall", c_inj, 7);
    check("reen_ready_rise", c_rdy, 12);

    // Bubble 16'h00F5 decodes to fine 6 and latches the flag
    check("bub_pre", bubble_err, 0);
    drive(7'd30, 16'h00F5, 4'd6, -1);
    drive(7'd31, 16'h0001, 4'd1, -1);
    check("bub_set", bubble_err, 1);
    drive(7'd32, 16'h0003, 4'd2, -1);
    drive(7'd33, 16'h0007, 4'd3, -1);
    check("bub_held", bubble_err, 1);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pd", pd, 1);
    check("arst_pd_inj", pd_inj, 1);
    check("arst_tdc_word", tdc_word, 0);
    check("arst_tdc_valid", tdc_valid, 0);
    check("arst_ready", ready, 0);
    check("arst_bubble_err", bubble_err, 0);
    check("arst_state", dut.state, OFF);
    sb.delete();
    en = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero settle: each wait state lasts one cycle
    power_up(8'd0, 8'd0, c_pd, c_inj, c_rdy, c_vld);
    check("z_pd_fall", c_pd, 1);
    check("z_inj_fall", c_inj, 2);
    check("z_ready_rise", c_rdy, 4);
    check("z_valid_rise", c_vld, 5);
    drive(7'd100, 16'h00FF, 4'd8, -1);
    drive(7'd101, 16'hFFFF, 4'd15, -1);
    en = 1'b0;
    void'(sb.pop_back());
    tick();
    tick();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
